// File: rtl/sti_dac_pkg.sv
// Shared definitions for the parametrised STI/DAC block.
// - state_t   : controller states
// - LEN_*     : pi_length codes (serial length in UNIT granules)
// - len_bits  : serial length in bits for a given length code
package sti_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FLUSH,
        ST_ZFILL,
        ST_DONE
    } state_t;

    localparam logic [1:0] LEN_1U = 2'd0;
    localparam logic [1:0] LEN_2U = 2'd1;
    localparam logic [1:0] LEN_3U = 2'd2;
    localparam logic [1:0] LEN_4U = 2'd3;

    function automatic int unsigned len_bits(input logic [1:0] code, input int unsigned unit);
        return unit * ({30'd0, code} + 32'd1);
    endfunction

endpackage

// File: rtl/sti_pix_pack.sv
// Bit-to-pixel packer with pixel-memory write port.
// Ports:
//   clk, reset                - clock, asynchronous active-low reset
//   bit_in, bit_valid         - serial bit stream to pack (first bit -> pixel MSB)
//   flush_req                 - write out a partial pixel, left-aligned and zero-padded
//   zero_req                  - write a zero pixel at the next address
//   pixel_wr/addr/dataout     - registered memory write port
//   full                      - sticky, set when the address wraps past MEM_DEPTH-1
//   at_last                   - next write will target MEM_DEPTH-1
module sti_pix_pack #(
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              flush_req,
    input  logic              zero_req,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              full,
    output logic              at_last
);

    localparam int                CNT_W     = $clog2(PIX_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic [PIX_W-1:0]  acc;
    logic [PIX_W-1:0]  acc_next;
    logic [PIX_W-1:0]  wr_data;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] next_addr;
    logic              pix_done;
    logic              flush_wr;
    logic              do_write;

    assign acc_next = (acc << 1) | PIX_W'(bit_in);
    assign pix_done = bit_valid && (cnt == CNT_W'(PIX_W - 1));
    assign flush_wr = flush_req && (cnt != '0);
    assign do_write = pix_done || flush_wr || zero_req;
    assign at_last  = (next_addr == LAST_ADDR);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_data = '0;
        if (pix_done)
            wr_data = acc_next;
        else if (flush_wr)
            // acc holds cnt bits right-aligned; move them to the MSB end
            wr_data = acc << (CNT_W'(PIX_W) - cnt);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc           <= '0;
            cnt           <= '0;
            pixel_wr      <= 1'b0;
            pixel_addr    <= '0;
            pixel_dataout <= '0;
            next_addr     <= '0;
            full          <= 1'b0;
        end else begin
            pixel_wr <= do_write;
            if (do_write) begin
                pixel_dataout <= wr_data;
                pixel_addr    <= next_addr;
                if (at_last) begin
                    next_addr <= '0;
                    full      <= 1'b1;
                end else begin
                    next_addr <= next_addr + 1'b1;
                end
            end
            if (pix_done || flush_wr) begin
                acc <= '0;
                cnt <= '0;
            end else if (bit_valid) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sti_dac_param.sv
// Parametrised serial transmitter and pixel-memory arranger.
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   load, pi_*            - capture request and formatting controls (sampled when busy=0)
//   pi_end                - end of stream: flush partial pixel, zero-fill memory, finish
//   busy                  - transmitting, flushing, zero-filling or done
//   so_data, so_valid     - serial output stream
//   pixel_wr/addr/dataout - pixel memory write port
//   pixel_finish          - sticky completion flag
module sti_dac_param
    import sti_dac_pkg::*;
#(
    parameter int UNIT      = 8,
    parameter int DATA_W    = 16,
    parameter int PIX_W     = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [1:0]        pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              busy,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish
);

    localparam int MAX_L = 4 * UNIT;
    localparam int CNT_W = $clog2(MAX_L);

    state_t           state;
    state_t           state_next;
    logic [MAX_L-1:0] word_fmt;
    logic [MAX_L-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] last_idx;
    logic             msb_first;
    logic             end_pending;
    int unsigned      len_l;
    logic             flush_req;
    logic             zero_req;
    logic             full;
    logic             at_last;

    // Word formatter: W is kept right-aligned in a MAX_L-bit field.
    always_comb begin
        len_l    = len_bits(pi_length, UNIT);
        word_fmt = '0;
        case (pi_length)
            LEN_1U:  word_fmt = {{(MAX_L-UNIT){1'b0}},
                                 (pi_low ? pi_data[DATA_W-1:UNIT] : pi_data[UNIT-1:0])};
            LEN_2U:  word_fmt = {{(MAX_L-DATA_W){1'b0}}, pi_data};
            default: begin
                word_fmt = {{(MAX_L-DATA_W){1'b0}}, pi_data};
                if (pi_fill)
                    word_fmt = word_fmt << (len_l - DATA_W);
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (load)
                          state_next = ST_SHIFT;
                      else if (pi_end)
                          state_next = ST_FLUSH;
            ST_SHIFT: if (bit_cnt == last_idx)
                          state_next = end_pending ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: state_next = ST_ZFILL;
            ST_ZFILL: if (full || at_last)
                          state_next = ST_DONE;
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            sreg         <= '0;
            bit_cnt      <= '0;
            last_idx     <= '0;
            msb_first    <= 1'b0;
            end_pending  <= 1'b0;
            pixel_finish <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && load) begin
                // MSB-first streams shift out of the top, so left-align W there
                sreg        <= pi_msb ? (word_fmt << (MAX_L - len_l)) : word_fmt;
                bit_cnt     <= '0;
                last_idx    <= CNT_W'(len_l - 1);
                msb_first   <= pi_msb;
                end_pending <= pi_end;
            end else if (state == ST_SHIFT) begin
                sreg    <= msb_first ? {sreg[MAX_L-2:0], 1'b0} : {1'b0, sreg[MAX_L-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (state == ST_FLUSH) begin
                end_pending <= 1'b0;
            end
            if (state == ST_DONE)
                pixel_finish <= 1'b1;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign so_valid  = (state == ST_SHIFT);
    assign so_data   = so_valid && (msb_first ? sreg[MAX_L-1] : sreg[0]);
    assign flush_req = (state == ST_FLUSH);
    assign zero_req  = (state == ST_ZFILL) && !full;

    sti_pix_pack #(
        .PIX_W    (PIX_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_pack (
        .clk          (clk),
        .reset        (reset),
        .bit_in       (so_data),
        .bit_valid    (so_valid),
        .flush_req    (flush_req),
        .zero_req     (zero_req),
        .pixel_wr     (pixel_wr),
        .pixel_addr   (pixel_addr),
        .pixel_dataout(pixel_dataout),
        .full         (full),
        .at_last      (at_last)
    );

endmodule

// File: tb/tb_sti_dac_param.sv
// Scoreboard bench for sti_dac_param: a PIX_W=8 instance for the main
// scenarios and a PIX_W=16, MEM_DEPTH=16 instance for the partial-pixel flush.
module tb_sti_dac_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        load16 = 1'b0;
    logic [15:0] pi_data = '0;
    logic [1:0]  pi_length = '0;
    logic        pi_fill = 1'b0;
    logic        pi_msb = 1'b0;
    logic        pi_low = 1'b0;
    logic        pi_end = 1'b0;
    logic        end16 = 1'b0;

    logic        busy, so_data, so_valid, pixel_wr, pixel_finish;
    logic [7:0]  pixel_addr, pixel_dataout;
    logic        busy16, so_data16, so_valid16, pixel_wr16, finish16;
    logic [7:0]  addr16;
    logic [15:0] dataout16;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic bit_q[$];
    wr_t  wr_q[$];
    wr_t  wr16_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sti_dac_param dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .busy(busy), .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
        .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout), .pixel_finish(pixel_finish)
    );

    sti_dac_param #(.PIX_W(16), .MEM_DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .load(load16), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(end16),
        .busy(busy16), .so_data(so_data16), .so_valid(so_valid16), .pixel_wr(pixel_wr16),
        .pixel_addr(addr16), .pixel_dataout(dataout16), .pixel_finish(finish16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an output.
    always @(negedge clk) begin
        wr_t w;
        if (reset) begin
            if (so_valid) begin
                if (bit_q.size() == 0) check("so_valid_extra", {31'd0, so_valid}, 32'd0);
                else check("so_data", {31'd0, so_data}, {31'd0, bit_q.pop_front()});
            end
            if (pixel_wr) begin
                if (wr_q.size() == 0) check("pixel_wr_extra", {31'd0, pixel_wr}, 32'd0);
                else begin
                    w = wr_q.pop_front();
                    check("pixel_addr", {24'd0, pixel_addr}, {24'd0, w.addr});
                    check("pixel_dataout", {24'd0, pixel_dataout}, {16'd0, w.data});
                end
            end
            if (pixel_wr16) begin
                if (wr16_q.size() == 0) check("pixel_wr16_extra", {31'd0, pixel_wr16}, 32'd0);
                else begin
                    w = wr16_q.pop_front();
                    check("pixel_addr16", {24'd0, addr16}, {24'd0, w.addr});
                    check("pixel_dataout16", {16'd0, dataout16}, {16'd0, w.data});
                end
            end
        end
    end

    task automatic push_bits(input logic [31:0] w, input int len, input logic msb);
        for (int i = 0; i < len; i++)
            bit_q.push_back(msb ? w[len-1-i] : w[i]);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        wr_q.push_back('{addr: a, data: d});
    endtask

    task automatic do_load(input logic [15:0] d, input logic [1:0] len, input logic fill,
                           input logic msb, input logic low, input logic endp);
        @(posedge clk); #1;
        pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
        load = 1'b1; pi_end = endp;
        @(posedge clk); #1;
        load = 1'b0; pi_end = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check(name, {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        bit_q.delete();
        wr_q.delete();
        wr16_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic check_drained(input string name);
        check({name, "_bits_left"}, bit_q.size(), 32'd0);
        check({name, "_writes_left"}, wr_q.size(), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_so_valid", {31'd0, so_valid}, 32'd0);
        check("rst_so_data", {31'd0, so_data}, 32'd0);
        check("rst_pixel_wr", {31'd0, pixel_wr}, 32'd0);
        check("rst_pixel_addr", {24'd0, pixel_addr}, 32'd0);
        check("rst_pixel_dataout", {24'd0, pixel_dataout}, 32'd0);
        check("rst_pixel_finish", {31'd0, pixel_finish}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1 unit, low byte, MSB first: 0x34 -> 0,0,1,1,0,1,0,0
        push_bits(32'h34, 8, 1'b1);
        push_wr(8'd0, 16'h34);
        do_load(16'h1234, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("t1_idle", 64);
        check_drained("t1");

        // Same word LSB first -> 0,0,1,0,1,1,0,0 = 0x2C
        apply_reset();
        push_bits(32'h34, 8, 1'b0);
        push_wr(8'd0, 16'h2C);
        do_load(16'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle("t2_idle", 64);
        // 2 units LSB first: 0x34 -> 0x2C, 0x12 -> 0x48, address continues
        push_bits(32'h1234, 16, 1'b0);
        push_wr(8'd1, 16'h2C);
        push_wr(8'd2, 16'h48);
        do_load(16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle("t2b_idle", 64);
        check_drained("t2");

        // Reset during bit 5 aborts everything; next load restarts at address 0
        push_bits(32'h34, 8, 1'b1);
        do_load(16'h1234, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        bit_q.delete();
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_so_valid", {31'd0, so_valid}, 32'd0);
        check("abort_pixel_wr", {31'd0, pixel_wr}, 32'd0);
        check("abort_pixel_addr", {24'd0, pixel_addr}, 32'd0);
        check("abort_pixel_dataout", {24'd0, pixel_dataout}, 32'd0);
        check("abort_pixel_finish", {31'd0, pixel_finish}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        push_bits(32'h34, 8, 1'b1);
        push_wr(8'd0, 16'h34);
        do_load(16'h1234, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("abort_idle", 64);
        check_drained("abort");

        // 4 units MSB first, fill=1 then fill=0, then 3 units fill=1
        apply_reset();
        push_bits(32'h12340000, 32, 1'b1);
        push_wr(8'd0, 16'h12); push_wr(8'd1, 16'h34); push_wr(8'd2, 16'h00); push_wr(8'd3, 16'h00);
        do_load(16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle("t3a_idle", 64);
        apply_reset();
        push_bits(32'h00001234, 32, 1'b1);
        push_wr(8'd0, 16'h00); push_wr(8'd1, 16'h00); push_wr(8'd2, 16'h12); push_wr(8'd3, 16'h34);
        do_load(16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("t3b_idle", 64);
        push_bits(32'h123400, 24, 1'b1);
        push_wr(8'd4, 16'h12); push_wr(8'd5, 16'h34); push_wr(8'd6, 16'h00);
        do_load(16'h1234, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_idle("t3c_idle", 64);
        check_drained("t3");

        // Two 1-unit loads (high byte, then low byte), load/pi_end while busy ignored
        apply_reset();
        push_bits(32'hA5, 8, 1'b1);
        push_wr(8'd0, 16'hA5);
        do_load(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        load = 1'b1; pi_end = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; pi_end = 1'b0;
        wait_idle("t4a_idle", 64);
        push_bits(32'h5A, 8, 1'b1);
        push_wr(8'd1, 16'h5A);
        do_load(16'hA55A, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle("t4b_idle", 64);
        for (int a = 2; a < 256; a++) push_wr(8'(a), 16'h0);
        @(posedge clk); #1;
        pi_end = 1'b1;
        @(posedge clk); #1;
        pi_end = 1'b0;
        begin
            int n = 0;
            while (!pixel_finish && n < 600) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("t4_finish", {31'd0, pixel_finish}, 32'd1);
        check("t4_busy_done", {31'd0, busy}, 32'd1);
        check("t4_last_addr", {24'd0, pixel_addr}, 32'd255);
        check_drained("t4");
        do_load(16'hFFFF, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("t4_finish_held", {31'd0, pixel_finish}, 32'd1);
        check("t4_busy_held", {31'd0, busy}, 32'd1);

        // PIX_W=16: load with pi_end -> flush 0x3400 @0, zero-fill 1..15
        wr16_q.push_back('{addr: 8'd0, data: 16'h3400});
        for (int a = 1; a < 16; a++) wr16_q.push_back('{addr: 8'(a), data: 16'h0});
        @(posedge clk); #1;
        pi_data = 16'h0034; pi_length = 2'd0; pi_fill = 1'b0; pi_msb = 1'b1; pi_low = 1'b0;
        load16 = 1'b1; end16 = 1'b1;
        @(posedge clk); #1;
        load16 = 1'b0; end16 = 1'b0;
        begin
            int n = 0;
            while (!finish16 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("t5_finish", {31'd0, finish16}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_writes_left", wr16_q.size(), 32'd0);
        check("t5_finish_held", {31'd0, finish16}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
